tohost_monitor: RTL and testbench
=================================

// Module: tohost_monitor
// PURPOSE
//  Consumes the tohost CSR write stream from the datapath coprocessor and decides the outcome
//  of a test program run: pass, fail or timeout.
//  Counts run cycles and retired instructions, and hands a result record to the host over a
//  valid/ready handshake.
//  Asserts halt so the core is frozen once a verdict exists.
//  Sits between the core's coprocessor (cp) tohost write port and the host/bench.
// PARAMETERS
//  TIMEOUT_CYCLES  100  RUN cycles allowed before a timeout verdict; must be >= 1
//  CNT_W           32   width of the cycle and retired-instruction counters
//  XLEN            32   width of tohost data
// PORTS
//  clk           in   1      system clock; all logic on posedge
//  reset         in   1      synchronous, active-high
//  start         in   1      begin a run; accepted in IDLE and DONE only
//  tohost_wr_en  in   1      cp writes tohost this cycle
//  tohost_wdata  in   XLEN   value being written to tohost
//  retire        in   1      one instruction retires this cycle (core not stalled)
//  busy          out  1      high in RUN
//  halt          out  1      high in REPORT and DONE; core must hold
//  res_valid     out  1      result record valid (REPORT state)
//  res_ready     in   1      host accepts the record
//  res_code      out  2      00 none, 01 pass, 10 fail, 11 timeout
//  res_tohost    out  XLEN   latched nonzero tohost value; 0 on timeout
//  res_cycles    out  CNT_W  RUN cycles, including the terminating cycle
//  res_retired   out  CNT_W  retires counted in RUN, including the terminating cycle
// BEHAVIOUR
//  - Reset: state IDLE; every output and internal counter is 0.
//  - Reset mid-operation behaves the same from any state.
//  - FSM IDLE -> RUN when start=1. Both counters load 0 on that edge.
//  - FSM RUN, each cycle:
//      - cyc <= cyc+1.
//      - ret <= ret+retire.
//      - Both counters saturate at all-ones and never wrap.
//  - RUN terminate on pass/fail: tohost_wr_en=1 && tohost_wdata!=0 -> REPORT.
//      - res_tohost <= wdata.
//      - res_code <= (wdata==1) ? 01 : 10.
//  - Writes of 0 to tohost are ignored.
//  - RUN terminate on timeout: cyc==TIMEOUT_CYCLES-1 with no terminating write -> REPORT.
//      - res_code <= 11.
//      - res_tohost <= 0.
//  - Simultaneous terminating write and timeout: the write wins (code 01/10).
//  - On termination:
//      - res_cycles <= cyc+1 (saturating).
//      - res_retired <= ret+retire (saturating).
//  - Latency: terminating event in RUN cycle N -> res_valid=1 in cycle N+1.
//  - REPORT:
//      - res_valid=1 and halt=1.
//      - All res_* fields are held stable until res_valid&&res_ready.
//      - On that handshake -> DONE.
//  - DONE:
//      - res_valid=0 and halt=1.
//      - res_* fields keep their values.
//      - start=1 -> RUN: counters are cleared and res_* fields are zeroed.
//  - start is ignored in RUN and REPORT.
//  - tohost writes are ignored outside RUN.
//  - busy=1 only in RUN.
//  - res_valid never drops without a handshake except on reset.
// TESTING
//  1. Pass:
//      - Stimulus: start, retire=1 every cycle, tohost_wr_en=1 with wdata=1 on the 6th RUN cycle.
//      - Response: next cycle res_valid=1, code=01, tohost=1, cycles=6, retired=6.
//  2. Fail after ignored zeros:
//      - Stimulus: write 0 on RUN cycles 2 and 3, then write 7 on cycle 4.
//      - Response: code=10, tohost=7, cycles=4.
//  3. Timeout:
//      - Stimulus: TIMEOUT_CYCLES=10, no writes.
//      - Response: res_valid on cycle 11, code=11, tohost=0, cycles=10.
//  4. Tie:
//      - Stimulus: TIMEOUT_CYCLES=10, write 1 on RUN cycle 10.
//      - Response: code=01 (pass beats timeout), cycles=10.
//  5. Backpressure:
//      - Stimulus: res_ready=0 for 4 cycles, then 1.
//      - Response: fields stable and halt=1 throughout; DONE follows with res_valid=0, halt=1.
//      - Follow-up stimulus: start.
//      - Follow-up response: RUN, busy=1, counters restart from 0.
//  6. Reset mid-run:
//      - Stimulus: reset=1 on RUN cycle 3.
//      - Response: next cycle IDLE, all outputs 0; a later write of 1 is ignored until start.

Source files
------------

// File: rtl/tohost_monitor.sv
// -----------------------------------------------------------------------------
// tohost_monitor
//
// Watches the coprocessor's tohost CSR write stream and decides the outcome of
// a test program run (pass / fail / timeout). While a run is active it counts
// run cycles and retired instructions. Once a verdict exists it freezes the
// core through halt. It then presents a result record to the host over a
// valid/ready handshake.
//
// Ports
//   clk           system clock, everything on posedge
//   reset         synchronous, active-high
//   start         begin a run (honoured in IDLE and DONE only)
//   tohost_wr_en  coprocessor writes tohost this cycle
//   tohost_wdata  value written to tohost
//   retire        one instruction retires this cycle
//   busy          high while a run is in progress
//   halt          high while a verdict is pending or delivered
//   res_valid     result record valid
//   res_ready     host accepts the record
//   res_code      00 none, 01 pass, 10 fail, 11 timeout
//   res_tohost    terminating nonzero tohost value, 0 on timeout
//   res_cycles    run cycles including the terminating one
//   res_retired   retires in the run including the terminating cycle
// -----------------------------------------------------------------------------
module tohost_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 100,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned XLEN           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             tohost_wr_en,
    input  logic [XLEN-1:0]  tohost_wdata,
    input  logic             retire,
    output logic             busy,
    output logic             halt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_code,
    output logic [XLEN-1:0]  res_tohost,
    output logic [CNT_W-1:0] res_cycles,
    output logic [CNT_W-1:0] res_retired
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_PASS    = 2'b01;
    localparam logic [1:0] CODE_FAIL    = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    // Counter value seen during the last permitted run cycle.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic [1:0]        code_q, code_d;
    logic [XLEN-1:0]   tohost_q, tohost_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    // Saturating "next" values of both counters. The same values serve as
    // counter updates and as the reported totals, so the terminating cycle is
    // included in the record.
    logic [CNT_W-1:0]  cyc_plus;
    logic [CNT_W-1:0]  ret_plus;
    logic              term_write;
    logic              timeout_hit;

    always_comb begin
        cyc_plus    = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
        ret_plus    = (retire && !(&ret_q)) ? ret_q + CNT_W'(1) : ret_q;
        term_write  = tohost_wr_en && (tohost_wdata != '0);
        timeout_hit = (cyc_q == TIMEOUT_LAST);
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        ret_d     = ret_q;
        code_d    = code_q;
        tohost_d  = tohost_q;
        cycles_d  = cycles_q;
        retired_d = retired_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cyc_d   = '0;
                    ret_d   = '0;
                end
            end

            ST_RUN: begin
                cyc_d = cyc_plus;
                ret_d = ret_plus;
                // A terminating write takes priority over a timeout landing
                // in the same cycle.
                if (term_write) begin
                    state_d   = ST_REPORT;
                    tohost_d  = tohost_wdata;
                    code_d    = (tohost_wdata == XLEN'(1)) ? CODE_PASS : CODE_FAIL;
                    cycles_d  = cyc_plus;
                    retired_d = ret_plus;
                end else if (timeout_hit) begin
                    state_d   = ST_REPORT;
                    tohost_d  = '0;
                    code_d    = CODE_TIMEOUT;
                    cycles_d  = cyc_plus;
                    retired_d = ret_plus;
                end
            end

            ST_REPORT: begin
                if (res_ready) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // A new run wipes the previous record as well as the counters.
                if (start) begin
                    state_d   = ST_RUN;
                    cyc_d     = '0;
                    ret_d     = '0;
                    code_d    = CODE_NONE;
                    tohost_d  = '0;
                    cycles_d  = '0;
                    retired_d = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cyc_q     <= '0;
            ret_q     <= '0;
            code_q    <= CODE_NONE;
            tohost_q  <= '0;
            cycles_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            ret_q     <= ret_d;
            code_q    <= code_d;
            tohost_q  <= tohost_d;
            cycles_q  <= cycles_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        busy        = (state_q == ST_RUN);
        halt        = (state_q == ST_REPORT) || (state_q == ST_DONE);
        res_valid   = (state_q == ST_REPORT);
        res_code    = code_q;
        res_tohost  = tohost_q;
        res_cycles  = cycles_q;
        res_retired = retired_q;
    end

endmodule

// File: tb/tb_tohost_monitor.sv
// -----------------------------------------------------------------------------
// Bench for tohost_monitor (TIMEOUT_CYCLES = 10). A table of run scenarios is
// applied in a loop; each scenario pushes its expected record into a
// scoreboard queue when the terminating stimulus is driven, and the record is
// popped and compared when the DUT hands it over. Backpressure and mid-run
// reset are covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_tohost_monitor;

    localparam int TMO = 10;

    logic        clk = 1'b0;
    logic        reset, start, tohost_wr_en, retire, res_ready;
    logic [31:0] tohost_wdata;
    logic        busy, halt, res_valid;
    logic [1:0]  res_code;
    logic [31:0] res_tohost, res_cycles, res_retired;

    tohost_monitor #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (32),
        .XLEN          (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .tohost_wr_en(tohost_wr_en),
        .tohost_wdata(tohost_wdata),
        .retire      (retire),
        .busy        (busy),
        .halt        (halt),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_code    (res_code),
        .res_tohost  (res_tohost),
        .res_cycles  (res_cycles),
        .res_retired (res_retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] tohost;
        logic [31:0] cycles;
        logic [31:0] retired;
    } rec_t;

    // wr_cycle 0 = no terminating write; ret_mode 0 none, 1 every cycle, 2 odd cycles
    typedef struct {
        int          wr_cycle;
        logic [31:0] wdata;
        int          zero_a;
        int          zero_b;
        int          ret_mode;
        rec_t        exp;
    } vec_t;

    rec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // One clock: any handshake about to happen pops and checks the scoreboard.
    task automatic step();
        rec_t e;
        if (res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_record", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rec_code", 32'(res_code), 32'(e.code));
                chk("rec_tohost", res_tohost, e.tohost);
                chk("rec_cycles", res_cycles, e.cycles);
                chk("rec_retired", res_retired, e.retired);
                $display("record code=%0d tohost=0x%08h cycles=%0d retired=%0d",
                         res_code, res_tohost, res_cycles, res_retired);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start        = 1'b0;
        tohost_wr_en = 1'b0;
        tohost_wdata = '0;
        retire       = 1'b0;
        res_ready    = 1'b0;
    endtask

    // Start a run and drive it until its terminating cycle; leaves DUT in REPORT.
    task automatic run_to_report(input vec_t v);
        int term;
        term  = (v.wr_cycle > 0 && v.wr_cycle <= TMO) ? v.wr_cycle : TMO;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_run", 32'(busy), 32'd1);
        chk("halt_run", 32'(halt), 32'd0);
        chk("res_cleared", 32'(res_code), 32'd0);
        for (int c = 1; c <= term; c++) begin
            tohost_wr_en = (c == v.wr_cycle) || (c == v.zero_a) || (c == v.zero_b);
            tohost_wdata = (c == v.wr_cycle) ? v.wdata : 32'd0;
            case (v.ret_mode)
                1:       retire = 1'b1;
                2:       retire = (c % 2) == 1;
                default: retire = 1'b0;
            endcase
            if (c == term) sb_q.push_back(v.exp);
            step();
            if (c < term) chk("early_valid", 32'(res_valid), 32'd0);
        end
        tohost_wr_en = 1'b0;
        tohost_wdata = '0;
        retire       = 1'b0;
        chk("latency_valid", 32'(res_valid), 32'd1);
        chk("report_halt", 32'(halt), 32'd1);
        chk("report_busy", 32'(busy), 32'd0);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("done_valid", 32'(res_valid), 32'd0);
        chk("done_halt", 32'(halt), 32'd1);
    endtask

    vec_t vecs[7];

    initial begin
        vec_t v;
        rec_t e;

        vecs[0] = '{6,  32'd1,          0, 0, 1, '{2'b01, 32'd1,          32'd6,  32'd6}};
        vecs[1] = '{4,  32'd7,          2, 3, 1, '{2'b10, 32'd7,          32'd4,  32'd4}};
        vecs[2] = '{0,  32'd0,          0, 0, 2, '{2'b11, 32'd0,          32'd10, 32'd5}};
        vecs[3] = '{10, 32'd1,          0, 0, 1, '{2'b01, 32'd1,          32'd10, 32'd10}};
        vecs[4] = '{1,  32'hDEAD_BEEF,  0, 0, 0, '{2'b10, 32'hDEAD_BEEF,  32'd1,  32'd0}};
        vecs[5] = '{10, 32'd2,          0, 0, 2, '{2'b10, 32'd2,          32'd10, 32'd5}};
        vecs[6] = '{0,  32'd0,          3, 5, 0, '{2'b11, 32'd0,          32'd10, 32'd0}};

        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_code", 32'(res_code), 32'd0);
        chk("rst_tohost", res_tohost, 32'd0);
        chk("rst_cycles", res_cycles, 32'd0);
        chk("rst_retired", res_retired, 32'd0);

        // Table-driven runs; the first starts from IDLE, the rest from DONE.
        for (int i = 0; i < 7; i++) begin
            $display("vector %0d wr_cycle=%0d wdata=0x%08h", i, vecs[i].wr_cycle, vecs[i].wdata);
            run_to_report(vecs[i]);
            accept();
        end

        // Backpressure: record must stay put while the host stalls.
        $display("sequence backpressure");
        v = '{2, 32'd3, 0, 0, 1, '{2'b10, 32'd3, 32'd2, 32'd2}};
        run_to_report(v);
        for (int k = 0; k < 4; k++) begin
            start        = 1'b1;
            tohost_wr_en = 1'b1;
            tohost_wdata = 32'd1;
            step();
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_halt", 32'(halt), 32'd1);
            chk("bp_code", 32'(res_code), 32'd2);
            chk("bp_tohost", res_tohost, 32'd3);
            chk("bp_cycles", res_cycles, 32'd2);
            chk("bp_retired", res_retired, 32'd2);
        end
        idle_inputs();
        accept();
        // DONE keeps the record and ignores tohost writes.
        tohost_wr_en = 1'b1;
        tohost_wdata = 32'd9;
        step();
        idle_inputs();
        chk("done_keep_code", 32'(res_code), 32'd2);
        chk("done_keep_tohost", res_tohost, 32'd3);
        chk("done_busy", 32'(busy), 32'd0);
        // Restart: counters begin from zero again.
        v = '{3, 32'd1, 0, 0, 1, '{2'b01, 32'd1, 32'd3, 32'd3}};
        run_to_report(v);
        accept();

        // Reset in the middle of a run.
        $display("sequence reset_mid_run");
        start = 1'b1;
        step();
        start  = 1'b0;
        retire = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset  = 1'b0;
        retire = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_halt", 32'(halt), 32'd0);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_code", 32'(res_code), 32'd0);
        chk("mid_rst_cycles", res_cycles, 32'd0);
        tohost_wr_en = 1'b1;
        tohost_wdata = 32'd1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_ignore_valid", 32'(res_valid), 32'd0);
            chk("idle_ignore_busy", 32'(busy), 32'd0);
        end
        idle_inputs();
        v = '{1, 32'd1, 0, 0, 1, '{2'b01, 32'd1, 32'd1, 32'd1}};
        run_to_report(v);
        accept();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
